// File: rtl/apb_slave_regfile.sv
// APB completer with a word-addressed register file and programmable wait states.
// Optional build macro APB_SLVERR_EN adds the PSLVERR port for out-of-range accesses.
module apb_slave_regfile #(
    parameter int unsigned size        = 32,
    parameter int unsigned ad_size     = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PSEL,
    input  logic               PEN,
    input  logic               PW,
    input  logic [ad_size-1:0] PADDR,
    input  logic [size-1:0]    PWDATA,
    output logic               PREADY,
`ifdef APB_SLVERR_EN
    output logic               PSLVERR,
`endif
    output logic [size-1:0]    PRDATA
);

    localparam int unsigned CW    = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int unsigned IDX_W = (DEPTH <= 1) ? 1 : $clog2(DEPTH);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] SETUP  = 2'b01;
    localparam logic [1:0] ACCESS = 2'b10;

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_next;
    logic               latch;
    logic               commit;
    logic [ad_size-1:0] addr_q;
    logic [size-1:0]    wdata_q;
    logic               pw_q;
    logic               in_range;
    logic [IDX_W-1:0]   idx;
    logic [size-1:0]    regs [DEPTH];

    assign in_range = (32'(addr_q) < 32'(DEPTH));
    assign idx      = addr_q[IDX_W-1:0];

    // State and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        latch      = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && !PEN) state_next = SETUP;
            end
            SETUP: begin
                latch      = 1'b1;
                cnt_next   = CW'(WAIT_CYCLES);
                state_next = PSEL ? ACCESS : IDLE;
            end
            ACCESS: begin
                if (!PSEL || !PEN) begin
                    state_next = IDLE;
                end else if (cnt != '0) begin
                    cnt_next = cnt - CW'(1);
                end else begin
                    commit     = pw_q && in_range;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Transfer attributes captured once in SETUP and held for the whole access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            pw_q    <= 1'b0;
        end else if (latch) begin
            addr_q  <= PADDR;
            wdata_q <= PWDATA;
            pw_q    <= PW;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (commit) begin
            regs[idx] <= wdata_q;
        end
    end

    // Responses decode from registered state only, so no input-to-output path exists
    always_comb begin
        PREADY = (state == ACCESS) && (cnt == '0);
        PRDATA = '0;
        if (PREADY && !pw_q && in_range) PRDATA = regs[idx];
    end

`ifdef APB_SLVERR_EN
    assign PSLVERR = PREADY && !in_range;
`endif

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: three instances with 0, 3 and 2 wait states.
// Honours APB_SLVERR_EN when the design is built with it.
module tb_apb_slave_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel   [3];
    logic        pen    [3];
    logic        pw     [3];
    logic [7:0]  paddr  [3];
    logic [31:0] pwdata [3];
    logic [31:0] prdata [3];
    logic        pready [3];
    logic        pslverr[3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_slave_regfile #(.size(32), .ad_size(8), .DEPTH(16), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .PSEL(psel[0]), .PEN(pen[0]), .PW(pw[0]),
        .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PREADY(pready[0]),
`ifdef APB_SLVERR_EN
        .PSLVERR(pslverr[0]),
`endif
        .PRDATA(prdata[0]));

    apb_slave_regfile #(.size(32), .ad_size(8), .DEPTH(16), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .PSEL(psel[1]), .PEN(pen[1]), .PW(pw[1]),
        .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PREADY(pready[1]),
`ifdef APB_SLVERR_EN
        .PSLVERR(pslverr[1]),
`endif
        .PRDATA(prdata[1]));

    apb_slave_regfile #(.size(32), .ad_size(8), .DEPTH(16), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .PSEL(psel[2]), .PEN(pen[2]), .PW(pw[2]),
        .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PREADY(pready[2]),
`ifdef APB_SLVERR_EN
        .PSLVERR(pslverr[2]),
`endif
        .PRDATA(prdata[2]));

`ifndef APB_SLVERR_EN
    initial for (int i = 0; i < 3; i++) pslverr[i] = 1'b0;
`endif

    typedef struct {
        int          inst;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          exp_waits;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic xfer(input int i, input bit w, input logic [7:0] a, input logic [31:0] d,
                        output int waits, output logic [31:0] rd, output logic se);
        bit done;
        done  = 1'b0;
        waits = 0;
        rd    = '0;
        se    = 1'b0;
        @(posedge clk); #1;
        psel[i] = 1'b1; pen[i] = 1'b0; pw[i] = w; paddr[i] = a; pwdata[i] = d;
        @(posedge clk); #1;
        pen[i] = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clk); #1;
            if (pready[i]) begin
                done = 1'b1;
                rd   = prdata[i];
                se   = pslverr[i];
            end else begin
                waits++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout inst=%0d addr=%0d actual=no_pready required=pready", i, a);
        end
        @(posedge clk); #1;
        psel[i] = 1'b0; pen[i] = 1'b0;
    endtask

    vec_t        vecs[$];
    int          waits;
    logic [31:0] rd;
    logic        se;

    initial begin
        for (int i = 0; i < 3; i++) begin
            psel[i] = 1'b0; pen[i] = 1'b0; pw[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_pready", 32'(pready[0]), 32'h0);
        chk("reset_prdata", prdata[0], 32'h0);

        // Reset mid-read: outputs must drop without a clock edge
        xfer(0, 1'b1, 8'd2, 32'hdeadface, waits, rd, se);
        @(posedge clk); #1;
        psel[0] = 1'b1; pen[0] = 1'b0; pw[0] = 1'b0; paddr[0] = 8'd2;
        @(posedge clk); #1 pen[0] = 1'b1;
        @(posedge clk); #1;
        chk("t1_pre_pready", 32'(pready[0]), 32'h1);
        chk("t1_pre_prdata", prdata[0], 32'hdeadface);
        #1 rst = 1'b1;
        psel[0] = 1'b0; pen[0] = 1'b0;
        #1;
        chk("t1_async_pready", 32'(pready[0]), 32'h0);
        chk("t1_async_prdata", prdata[0], 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        for (int a = 0; a < 16; a++) begin
            xfer(0, 1'b0, 8'(a), 32'h0, waits, rd, se);
            chk($sformatf("t1_clear_reg%0d", a), rd, 32'h0);
        end

        vecs.push_back('{0, 1'b1, 8'd2,  32'hdeadface, 0, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b0, 8'd2,  32'h0,        0, 32'hdeadface, 1'b0});
        vecs.push_back('{1, 1'b1, 8'd5,  32'ha5a50001, 3, 32'h0,        1'b0});
        vecs.push_back('{1, 1'b0, 8'd5,  32'h0,        3, 32'ha5a50001, 1'b0});
        vecs.push_back('{0, 1'b1, 8'd20, 32'h12345678, 0, 32'h0,        1'b1});
        vecs.push_back('{0, 1'b0, 8'd20, 32'h0,        0, 32'h0,        1'b1});
        vecs.push_back('{0, 1'b0, 8'd2,  32'h0,        0, 32'hdeadface, 1'b0});
        vecs.push_back('{0, 1'b0, 8'd4,  32'h0,        0, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b1, 8'd15, 32'h0f0f0f0f, 0, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b0, 8'd15, 32'h0,        0, 32'h0f0f0f0f, 1'b0});
        vecs.push_back('{0, 1'b1, 8'd16, 32'hcafef00d, 0, 32'h0,        1'b1});
        vecs.push_back('{0, 1'b0, 8'd0,  32'h0,        0, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b1, 8'd2,  32'h11111111, 0, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b0, 8'd2,  32'h0,        0, 32'h11111111, 1'b0});
        vecs.push_back('{2, 1'b1, 8'd4,  32'h44444444, 2, 32'h0,        1'b0});
        vecs.push_back('{2, 1'b0, 8'd4,  32'h0,        2, 32'h44444444, 1'b0});

        foreach (vecs[n]) begin
            xfer(vecs[n].inst, vecs[n].wr, vecs[n].addr, vecs[n].wdata, waits, rd, se);
            chk($sformatf("vec%0d_waits", n), 32'(waits), 32'(vecs[n].exp_waits));
            chk($sformatf("vec%0d_rdata", n), rd, vecs[n].exp_rdata);
`ifdef APB_SLVERR_EN
            chk($sformatf("vec%0d_slverr", n), 32'(se), 32'(vecs[n].exp_err));
`endif
        end

        // Abort: PSEL dropped in a wait cycle discards the write
        @(posedge clk); #1;
        psel[2] = 1'b1; pen[2] = 1'b0; pw[2] = 1'b1; paddr[2] = 8'd4; pwdata[2] = 32'h99999999;
        @(posedge clk); #1 pen[2] = 1'b1;
        @(posedge clk); #1;
        chk("t5_wait_pready", 32'(pready[2]), 32'h0);
        psel[2] = 1'b0; pen[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("t5_abort_pready%0d", k), 32'(pready[2]), 32'h0);
        end
        xfer(2, 1'b0, 8'd4, 32'h0, waits, rd, se);
        chk("t5_keep_rdata", rd, 32'h44444444);
        chk("t5_keep_waits", 32'(waits), 32'd2);

        // Reset in ACCESS of a write: nothing commits, next transfer is normal
        @(posedge clk); #1;
        psel[1] = 1'b1; pen[1] = 1'b0; pw[1] = 1'b1; paddr[1] = 8'd7; pwdata[1] = 32'h77777777;
        @(posedge clk); #1 pen[1] = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        psel[1] = 1'b0; pen[1] = 1'b0;
        #1;
        chk("t6_rst_pready", 32'(pready[1]), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        xfer(1, 1'b0, 8'd7, 32'h0, waits, rd, se);
        chk("t6_reg7", rd, 32'h0);
        chk("t6_waits", 32'(waits), 32'd3);
        xfer(1, 1'b1, 8'd7, 32'h0badc0de, waits, rd, se);
        xfer(1, 1'b0, 8'd7, 32'h0, waits, rd, se);
        chk("t6_after_rdata", rd, 32'h0badc0de);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
